// File: rtl/spinner_pkg.sv
// Shared types and helpers for the rotary spinner quadrature generator.
// Holds the Gray phase codes, the phase successor and the saturating position add.
package spinner_pkg;

  localparam int unsigned POS_W = 12;

  typedef logic signed [POS_W-1:0] pos_t;

  localparam pos_t POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  localparam pos_t POS_MAX = {1'b0, {(POS_W-1){1'b1}}};

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // Negative motion walks 00->01->11->10; positive walks the reverse.
  function automatic logic [1:0] next_phase(input logic [1:0] cur, input logic dir_neg);
    logic [1:0] nxt;
    nxt = PH_00;
    case (cur)
      PH_00:   nxt = dir_neg ? PH_01 : PH_10;
      PH_01:   nxt = dir_neg ? PH_11 : PH_00;
      PH_11:   nxt = dir_neg ? PH_10 : PH_01;
      default: nxt = dir_neg ? PH_00 : PH_11;
    endcase
    return nxt;
  endfunction

  // Signed add clamped to the representable position range.
  function automatic pos_t sat_add(input pos_t a, input pos_t b);
    logic [POS_W:0] sum;
    pos_t           res;
    sum = {a[POS_W-1], a} + {b[POS_W-1], b};
    res = sum[POS_W-1:0];
    if (sum[POS_W] != sum[POS_W-1]) begin
      res = sum[POS_W] ? POS_MIN : POS_MAX;
    end
    return res;
  endfunction

endpackage

// File: rtl/spinner_tick_gen.sv
// Free-running clock-enable and step-rate dividers for the spinner.
// tick_c fires once per CE_DIV clocks; step_c fires on every STEP_DIV-th tick.
module spinner_tick_gen #(
  parameter int unsigned CE_DIV   = 8,
  parameter int unsigned STEP_DIV = 1500
) (
  input  logic clk_sys,
  input  logic reset,
  output logic tick_c,
  output logic step_c
);

  localparam int unsigned CE_W = $clog2(CE_DIV + 1);
  localparam int unsigned ST_W = $clog2(STEP_DIV + 1);

  logic [CE_W-1:0] ce_q, ce_d;
  logic [ST_W-1:0] st_q, st_d;

  always_comb begin
    ce_d   = ce_q;
    st_d   = st_q;
    tick_c = (ce_q == '0);
    step_c = tick_c && (st_q == '0);
    ce_d   = (ce_q == CE_W'(CE_DIV - 1)) ? '0 : ce_q + CE_W'(1);
    if (tick_c) begin
      st_d = (st_q == ST_W'(STEP_DIV - 1)) ? '0 : st_q + ST_W'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ce_q <= '0;
      st_q <= '0;
    end else begin
      ce_q <= ce_d;
      st_q <= st_d;
    end
  end

endmodule

// File: rtl/spinner_quad_gen.sv
// Rotary spinner emulation: accumulates mouse X (and optional D-pad) motion and
// drains it as Gray quadrature steps. D-pad support is built with SPINNER_DPAD_EN.
module spinner_quad_gen
  import spinner_pkg::*;
#(
  parameter int unsigned CE_DIV    = 8,
  parameter int unsigned STEP_DIV  = 1500,
  parameter int unsigned DPAD_POLL = 48000,
  parameter int unsigned DPAD_SLOW = 4,
  parameter int unsigned DPAD_FAST = 9
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       mouse_strobe,
  input  logic [8:0] mouse_x,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fast,
  output logic [1:0] enc_out,
  output logic       busy
);

  logic       tick_c;
  logic       step_c;
  pos_t       pos_q, pos_d;
  logic [1:0] enc_q, enc_d;
  logic       busy_q, busy_d;
  pos_t       mouse_ext_c;

  spinner_tick_gen #(
    .CE_DIV  (CE_DIV),
    .STEP_DIV(STEP_DIV)
  ) u_tick_gen (
    .clk_sys(clk_sys),
    .reset  (reset),
    .tick_c (tick_c),
    .step_c (step_c)
  );

  assign mouse_ext_c = {{(POS_W-9){mouse_x[8]}}, mouse_x};

`ifdef SPINNER_DPAD_EN
  localparam int unsigned DP_W = $clog2(DPAD_POLL + 1);

  logic [DP_W-1:0] dcnt_q, dcnt_d;
  logic            dpad_load_c;
  pos_t            mag_c;
  pos_t            dpad_val_c;

  // Poll counter runs only while a direction is held; wrap triggers a reload.
  always_comb begin
    dcnt_d      = dcnt_q;
    dpad_load_c = 1'b0;
    mag_c       = btn_fast ? POS_W'(DPAD_FAST) : POS_W'(DPAD_SLOW);
    dpad_val_c  = btn_right ? mag_c : -mag_c;
    if (!(btn_left || btn_right)) begin
      dcnt_d = '0;
    end else if (tick_c) begin
      if (dcnt_q == DP_W'(DPAD_POLL - 1)) begin
        dcnt_d      = '0;
        dpad_load_c = 1'b1;
      end else begin
        dcnt_d = dcnt_q + DP_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dcnt_q <= '0;
    end else begin
      dcnt_q <= dcnt_d;
    end
  end
`else
  logic unused_dpad;
  assign unused_dpad = ^{btn_left, btn_right, btn_fast, tick_c,
                         32'(DPAD_POLL + DPAD_SLOW + DPAD_FAST)};
`endif

  // Order within a cycle: step, then D-pad load overrides position, then mouse add.
  always_comb begin
    pos_d = pos_q;
    enc_d = enc_q;
    if (step_c && (pos_q != '0)) begin
      enc_d = next_phase(enc_q, pos_q[POS_W-1]);
      pos_d = pos_q[POS_W-1] ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    end
`ifdef SPINNER_DPAD_EN
    if (dpad_load_c) begin
      pos_d = dpad_val_c;
    end
`endif
    if (mouse_strobe) begin
      pos_d = sat_add(pos_d, mouse_ext_c);
    end
    busy_d = (pos_d != '0);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pos_q  <= '0;
      enc_q  <= PH_00;
      busy_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      enc_q  <= enc_d;
      busy_q <= busy_d;
    end
  end

  assign enc_out = enc_q;
  assign busy    = busy_q;

endmodule
